// File: rtl/board_ctl.sv
// rtl/board_ctl.sv - tic-tac-toe board controller: hover decode, move latch, win/draw detect
// Optional win-line output enabled by defining BOARD_WIN_LINE_EN.
module board_ctl #(
  parameter int COL1  = 339,
  parameter int COL2  = 686,
  parameter int ROW1  = 257,
  parameter int ROW2  = 515,
  parameter int H_MAX = 1023,
  parameter int V_MAX = 767
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        mouse_left,
  input  logic        new_game,
  output logic [8:0]  square,
  output logic [8:0]  cell_x,
  output logic [8:0]  cell_o,
  output logic        turn,
  output logic [1:0]  game_state,
  output logic [1:0]  winner
`ifdef BOARD_WIN_LINE_EN
  ,
  output logic [8:0]  win_line
`endif
);

  localparam logic [11:0] COL1_V  = 12'(COL1);
  localparam logic [11:0] COL2_V  = 12'(COL2);
  localparam logic [11:0] ROW1_V  = 12'(ROW1);
  localparam logic [11:0] ROW2_V  = 12'(ROW2);
  localparam logic [11:0] H_MAX_V = 12'(H_MAX);
  localparam logic [11:0] V_MAX_V = 12'(V_MAX);

  localparam logic [1:0] ST_PLAY  = 2'b00;
  localparam logic [1:0] ST_CHECK = 2'b01;
  localparam logic [1:0] ST_WIN   = 2'b10;
  localparam logic [1:0] ST_DRAW  = 2'b11;

  // Index 0 has the highest priority: rows, then cols, then main and anti diagonal.
  localparam logic [7:0][8:0] LINES = {
    9'b001010100, 9'b100010001,
    9'b100100100, 9'b010010010, 9'b001001001,
    9'b111000000, 9'b000111000, 9'b000000111
  };

  logic [1:0] state_q, state_d;
  logic [8:0] cell_x_q, cell_x_d;
  logic [8:0] cell_o_q, cell_o_d;
  logic [8:0] square_q, square_d;
  logic [8:0] win_line_q, win_line_d;
  logic [1:0] winner_q, winner_d;
  logic [3:0] moves_q, moves_d;
  logic       turn_q, turn_d;
  logic       mouse_left_q;

  logic [1:0] col, row;
  logic       pos_valid, cell_empty, click;
  logic [3:0] cell_idx;
  logic [8:0] hover_oh, mover_mask, win_mask;

  function automatic logic [8:0] first_line(input logic [8:0] m);
    first_line = 9'd0;
    for (int i = 7; i >= 0; i--) begin
      if ((m & LINES[i]) == LINES[i]) first_line = LINES[i];
    end
  endfunction

  always_comb begin
    if (xpos < COL1_V)      col = 2'd0;
    else if (xpos < COL2_V) col = 2'd1;
    else                    col = 2'd2;
    if (ypos < ROW1_V)      row = 2'd0;
    else if (ypos < ROW2_V) row = 2'd1;
    else                    row = 2'd2;
    pos_valid  = (xpos <= H_MAX_V) && (ypos <= V_MAX_V);
    cell_idx   = {2'b00, row} * 4'd3 + {2'b00, col};
    hover_oh   = 9'd1 << cell_idx;
    cell_empty = ((cell_x_q | cell_o_q) & hover_oh) == 9'd0;
    click      = mouse_left & ~mouse_left_q;
    mover_mask = turn_q ? cell_o_q : cell_x_q;
    win_mask   = first_line(mover_mask);
  end

  // new_game clears everything exactly like rst, overriding any same-cycle click.
  always_ff @(posedge pclk) begin
    if (rst || new_game) begin
      state_q      <= ST_PLAY;
      cell_x_q     <= 9'd0;
      cell_o_q     <= 9'd0;
      square_q     <= 9'd0;
      win_line_q   <= 9'd0;
      winner_q     <= 2'b00;
      moves_q      <= 4'd0;
      turn_q       <= 1'b0;
      mouse_left_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cell_x_q     <= cell_x_d;
      cell_o_q     <= cell_o_d;
      square_q     <= square_d;
      win_line_q   <= win_line_d;
      winner_q     <= winner_d;
      moves_q      <= moves_d;
      turn_q       <= turn_d;
      mouse_left_q <= mouse_left;
    end
  end

  always_comb begin
    state_d    = state_q;
    cell_x_d   = cell_x_q;
    cell_o_d   = cell_o_q;
    win_line_d = win_line_q;
    winner_d   = winner_q;
    moves_d    = moves_q;
    turn_d     = turn_q;
    square_d   = (state_q == ST_PLAY && pos_valid && cell_empty) ? hover_oh : 9'd0;
    case (state_q)
      ST_PLAY: begin
        if (click && pos_valid && cell_empty) begin
          if (turn_q) cell_o_d = cell_o_q | hover_oh;
          else        cell_x_d = cell_x_q | hover_oh;
          moves_d = moves_q + 4'd1;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (win_mask != 9'd0) begin
          state_d    = ST_WIN;
          winner_d   = turn_q ? 2'b10 : 2'b01;
          win_line_d = win_mask;
        end else if (moves_q == 4'd9) begin
          state_d = ST_DRAW;
        end else begin
          turn_d  = ~turn_q;
          state_d = ST_PLAY;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    square     = square_q;
    cell_x     = cell_x_q;
    cell_o     = cell_o_q;
    turn       = turn_q;
    game_state = state_q;
    winner     = winner_q;
  end

`ifdef BOARD_WIN_LINE_EN
  assign win_line = win_line_q;
`else
  logic unused_win_line;
  assign unused_win_line = ^win_line_q;
`endif

endmodule

// File: tb/tb_board_ctl.sv
// tb/tb_board_ctl.sv - directed self-checking bench for board_ctl
module tb_board_ctl;

  logic        pclk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] xpos = 12'd2000;
  logic [11:0] ypos = 12'd2000;
  logic        mouse_left = 1'b0;
  logic        new_game = 1'b0;
  logic [8:0]  square, cell_x, cell_o;
  logic        turn;
  logic [1:0]  game_state, winner;
`ifdef BOARD_WIN_LINE_EN
  logic [8:0]  win_line;
`endif

  int total = 0;
  int bad = 0;

  board_ctl dut (
    .pclk(pclk), .rst(rst), .xpos(xpos), .ypos(ypos),
    .mouse_left(mouse_left), .new_game(new_game),
    .square(square), .cell_x(cell_x), .cell_o(cell_o),
    .turn(turn), .game_state(game_state), .winner(winner)
`ifdef BOARD_WIN_LINE_EN
    , .win_line(win_line)
`endif
  );

  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  function automatic logic [11:0] cx(input int k);
    case ((k - 1) % 3)
      0:       cx = 12'd100;
      1:       cx = 12'd500;
      default: cx = 12'd900;
    endcase
  endfunction

  function automatic logic [11:0] cy(input int k);
    case ((k - 1) / 3)
      0:       cy = 12'd100;
      1:       cy = 12'd400;
      default: cy = 12'd700;
    endcase
  endfunction

  task automatic click(input int k);
    xpos = cx(k);
    ypos = cy(k);
    mouse_left = 1'b1;
    tick();
    mouse_left = 1'b0;
    tick();
    tick();
  endtask

  task automatic clear_board();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (square !== 9'd0) begin bad++; $display("FAIL reset_square got=%h exp=0", square); end
    total++; if (cell_x !== 9'd0 || cell_o !== 9'd0) begin bad++; $display("FAIL reset_cells got=%h/%h exp=0/0", cell_x, cell_o); end
    total++; if (turn !== 1'b0 || game_state !== 2'b00 || winner !== 2'b00) begin
      bad++; $display("FAIL reset_state got turn=%b st=%b win=%b exp 0/00/00", turn, game_state, winner); end
  endtask

  task automatic test_hover();
    xpos = 12'd100; ypos = 12'd600; tick();
    total++; if (square !== 9'b001000000) begin bad++; $display("FAIL hover_cell7 got=%b exp=001000000", square); end
    xpos = 12'd338; tick();
    total++; if (square !== 9'b001000000) begin bad++; $display("FAIL hover_x338 got=%b exp=001000000", square); end
    xpos = 12'd339; tick();
    total++; if (square !== 9'b010000000) begin bad++; $display("FAIL hover_x339 got=%b exp=010000000", square); end
    ypos = 12'd800; tick();
    total++; if (square !== 9'd0) begin bad++; $display("FAIL hover_y800 got=%b exp=0", square); end
    xpos = 12'd1023; ypos = 12'd767; tick();
    total++; if (square !== 9'b100000000) begin bad++; $display("FAIL hover_max got=%b exp=100000000", square); end
    xpos = 12'd1024; tick();
    total++; if (square !== 9'd0) begin bad++; $display("FAIL hover_x1024 got=%b exp=0", square); end
    xpos = 12'd100; ypos = 12'd256; tick();
    total++; if (square !== 9'b000000001) begin bad++; $display("FAIL hover_y256 got=%b exp=000000001", square); end
    ypos = 12'd257; tick();
    total++; if (square !== 9'b000001000) begin bad++; $display("FAIL hover_y257 got=%b exp=000001000", square); end
    xpos = 12'd685; ypos = 12'd515; tick();
    total++; if (square !== 9'b010000000) begin bad++; $display("FAIL hover_x685_y515 got=%b exp=010000000", square); end
  endtask

  task automatic test_move();
    clear_board();
    xpos = 12'd100; ypos = 12'd100; mouse_left = 1'b1; tick();
    total++; if (cell_x !== 9'b000000001 || game_state !== 2'b01 || turn !== 1'b0) begin
      bad++; $display("FAIL move_check got x=%b st=%b turn=%b exp 000000001/01/0", cell_x, game_state, turn); end
    mouse_left = 1'b0; tick();
    total++; if (game_state !== 2'b00 || turn !== 1'b1) begin
      bad++; $display("FAIL move_verdict got st=%b turn=%b exp 00/1", game_state, turn); end
    tick();
    total++; if (square !== 9'd0) begin bad++; $display("FAIL move_occupied_hover got=%b exp=0", square); end
    click(1);
    total++; if (cell_x !== 9'b000000001 || cell_o !== 9'd0 || turn !== 1'b1 || game_state !== 2'b00) begin
      bad++; $display("FAIL move_reclick got x=%b o=%b turn=%b st=%b", cell_x, cell_o, turn, game_state); end
    click(2);
    total++; if (cell_o !== 9'b000000010 || turn !== 1'b0) begin
      bad++; $display("FAIL move_o got o=%b turn=%b exp 000000010/0", cell_o, turn); end
  endtask

  task automatic play_x_win();
    clear_board();
    click(1); click(4); click(2); click(5); click(3);
  endtask

  task automatic test_x_wins();
    play_x_win();
    total++; if (cell_x !== 9'b000000111 || cell_o !== 9'b000011000) begin
      bad++; $display("FAIL win_cells got x=%b o=%b exp 000000111/000011000", cell_x, cell_o); end
    total++; if (game_state !== 2'b10 || winner !== 2'b01 || turn !== 1'b0) begin
      bad++; $display("FAIL win_state got st=%b win=%b turn=%b exp 10/01/0", game_state, winner, turn); end
`ifdef BOARD_WIN_LINE_EN
    total++; if (win_line !== 9'b000000111) begin bad++; $display("FAIL win_line got=%b exp=000000111", win_line); end
`endif
    click(6);
    total++; if (cell_x !== 9'b000000111 || cell_o !== 9'b000011000 || game_state !== 2'b10) begin
      bad++; $display("FAIL win_frozen got x=%b o=%b st=%b", cell_x, cell_o, game_state); end
    total++; if (square !== 9'd0) begin bad++; $display("FAIL win_hover got=%b exp=0", square); end
  endtask

  task automatic test_o_diag_win();
    clear_board();
    click(1); click(3); click(2); click(5); click(9); click(7);
    total++; if (game_state !== 2'b10 || winner !== 2'b10 || cell_o !== 9'b001010100) begin
      bad++; $display("FAIL o_win got st=%b win=%b o=%b exp 10/10/001010100", game_state, winner, cell_o); end
`ifdef BOARD_WIN_LINE_EN
    total++; if (win_line !== 9'b001010100) begin bad++; $display("FAIL o_win_line got=%b exp=001010100", win_line); end
`endif
  endtask

  task automatic test_draw();
    clear_board();
    click(1); click(2); click(3); click(5); click(4);
    click(6); click(8); click(7); click(9);
    total++; if (game_state !== 2'b11 || winner !== 2'b00) begin
      bad++; $display("FAIL draw_state got st=%b win=%b exp 11/00", game_state, winner); end
    total++; if ((cell_x | cell_o) !== 9'h1FF || (cell_x & cell_o) !== 9'd0) begin
      bad++; $display("FAIL draw_full got x=%b o=%b", cell_x, cell_o); end
    total++; if (cell_x !== 9'b110001101) begin bad++; $display("FAIL draw_x got=%b exp=110001101", cell_x); end
  endtask

  task automatic test_hold();
    clear_board();
    xpos = cx(5); ypos = cy(5); mouse_left = 1'b1;
    for (int i = 0; i < 50; i++) tick();
    mouse_left = 1'b0; tick();
    total++; if (cell_x !== 9'b000010000 || cell_o !== 9'd0 || turn !== 1'b1 || game_state !== 2'b00) begin
      bad++; $display("FAIL hold got x=%b o=%b turn=%b st=%b", cell_x, cell_o, turn, game_state); end
  endtask

  task automatic test_new_game();
    clear_board();
    xpos = cx(1); ypos = cy(1); mouse_left = 1'b1; new_game = 1'b1; tick();
    total++; if (cell_x !== 9'd0 || game_state !== 2'b00) begin
      bad++; $display("FAIL ng_click got x=%b st=%b exp 0/00", cell_x, game_state); end
    mouse_left = 1'b0; new_game = 1'b0; tick(); tick();
    total++; if (cell_x !== 9'd0 || cell_o !== 9'd0) begin
      bad++; $display("FAIL ng_after got x=%b o=%b exp 0/0", cell_x, cell_o); end
    play_x_win();
    xpos = 12'd2000; new_game = 1'b1; tick(); new_game = 1'b0;
    total++; if (cell_x !== 9'd0 || cell_o !== 9'd0 || turn !== 1'b0 || game_state !== 2'b00 || winner !== 2'b00 || square !== 9'd0) begin
      bad++; $display("FAIL ng_win got x=%b o=%b turn=%b st=%b win=%b sq=%b", cell_x, cell_o, turn, game_state, winner, square); end
`ifdef BOARD_WIN_LINE_EN
    total++; if (win_line !== 9'd0) begin bad++; $display("FAIL ng_win_line got=%b exp=0", win_line); end
`endif
  endtask

  task automatic test_rst_check();
    clear_board();
    click(2);
    xpos = cx(3); ypos = cy(3); mouse_left = 1'b1; tick();
    total++; if (game_state !== 2'b01 || cell_o !== 9'b000000100) begin
      bad++; $display("FAIL rst_pre got st=%b o=%b exp 01/000000100", game_state, cell_o); end
    rst = 1'b1; tick(); rst = 1'b0; mouse_left = 1'b0;
    total++; if (cell_x !== 9'd0 || cell_o !== 9'd0 || turn !== 1'b0 || game_state !== 2'b00 || winner !== 2'b00 || square !== 9'd0) begin
      bad++; $display("FAIL rst_check got x=%b o=%b turn=%b st=%b win=%b sq=%b", cell_x, cell_o, turn, game_state, winner, square); end
  endtask

  initial begin
    test_reset();
    test_hover();
    test_move();
    test_x_wins();
    test_o_diag_win();
    test_draw();
    test_hold();
    test_new_game();
    test_rst_check();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
